apb_sram_master: RTL and testbench
==================================

// Module: apb_sram_master
// PURPOSE
//  APB requester that drives the master side of apb_sram_if toward the SRAM slave.
//  Accepts one command at a time on a valid/ready port.
//  Sequences the APB SETUP and ACCESS phases and waits on PREADY.
//  Returns read data and error status on a valid/ready response port.
//  Used by the test harness and the on-chip init/scrub sequencer as the APB initiator.
// PARAMETERS
//  ADDR_W          32   width of PADDR / cmd_addr
//  DATA_W          32   width of PWDATA, PRDATA, cmd_wdata, rsp_rdata
//  TIMEOUT_CYCLES  16   max ACCESS cycles with PREADY low before abort; 0 = timeout disabled
// PORTS
//  PCLK       in   1       APB clock; all logic is on the rising edge
//  PRESETn    in   1       asynchronous, active-low reset
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       block can accept a command (high only in IDLE)
//  cmd_write  in   1       1 = write, 0 = read
//  cmd_addr   in   ADDR_W  target address
//  cmd_wdata  in   DATA_W  write data; ignored for reads
//  rsp_valid  out  1       response present
//  rsp_ready  in   1       consumer accepts the response
//  rsp_rdata  out  DATA_W  read data; 0 for writes and for timed-out transfers
//  rsp_err    out  1       PSLVERR sampled at completion, OR timeout
//  rsp_tmo    out  1       transfer was aborted by timeout
//  busy       out  1       state != IDLE
//  PADDR, PSEL, PENABLE, PWRITE, PWDATA   out  per apb_sram_if  APB request
//  PREADY, PSLVERR, PRDATA                in   per apb_sram_if  APB response
// BEHAVIOUR
//  Clock and reset
//   - One clock, PCLK. Reset PRESETn is asynchronous and active-low.
//   - All outputs are registered except cmd_ready and busy, which decode the state register.
//   - Reset values: state = IDLE; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
//     rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; rsp_tmo = 0; timeout counter = 0.
//   - PSEL and PENABLE are never X/Z after reset.
//  FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE
//   - IDLE: cmd_ready = 1. On cmd_valid at the edge, capture cmd_addr/write/wdata into
//     PADDR/PWRITE/PWDATA; next = SETUP.
//   - SETUP: PSEL = 1, PENABLE = 0. Lasts exactly 1 cycle; next = ACCESS.
//   - ACCESS: PSEL = 1, PENABLE = 1.
//       - PREADY = 1 at the edge: capture rsp_rdata = PWRITE ? 0 : PRDATA; rsp_err = PSLVERR;
//         rsp_tmo = 0; rsp_valid = 1; PSEL = 0; PENABLE = 0; next = RESP.
//       - PREADY = 0: the timeout counter increments.
//       - Counter reaches TIMEOUT_CYCLES while PREADY = 0: rsp_err = 1, rsp_tmo = 1,
//         rsp_rdata = 0; drop PSEL/PENABLE; next = RESP.
//       - If PREADY = 1 on the same edge the count would hit the limit, PREADY wins
//         (normal completion).
//   - RESP: PSEL = 0, PENABLE = 0, rsp_valid = 1, rsp fields held stable.
//       - On rsp_ready at the edge: rsp_valid -> 0; next = IDLE.
//  Latency
//   - Command accepted at edge N: SETUP in cycle N+1, ACCESS in N+2.
//   - If PREADY = 1 in N+2, rsp_valid = 1 from N+3.
//   - Minimum command-to-command spacing is 4 cycles when rsp_ready is held high.
//  Invariants
//   - PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS; in other
//     states they hold their last value.
//   - PENABLE = 1 implies PSEL = 1.
//   - Timeout counter clears on entry to SETUP.
//   - cmd_valid is ignored outside IDLE; no command is lost because cmd_ready = 0.
//  Reset mid-transfer: all outputs return to their reset values immediately; the transfer
//   is dropped and no response is produced.
// TESTING
//  1. Write 0xA5A5_0001 to 0x10, PREADY = 1 in the first ACCESS cycle
//     -> PSEL = 1 for 2 cycles; rsp_valid at N+3; rsp_err = 0; rsp_rdata = 0.
//  2. Read 0x10, slave returns PRDATA = 0xDEAD_BEEF after 3 wait states
//     -> ACCESS lasts 4 cycles; rsp_rdata = 0xDEAD_BEEF; PADDR stable throughout.
//  3. Read with PSLVERR = 1 at completion -> rsp_err = 1, rsp_tmo = 0.
//  4. TIMEOUT_CYCLES = 4, PREADY held 0 -> after 4 ACCESS cycles PSEL drops;
//     rsp_err = 1, rsp_tmo = 1, rsp_rdata = 0.
//  5. rsp_ready held 0 for 5 cycles while cmd_valid = 1
//     -> rsp stable, cmd_ready = 0, no new SETUP until after the response handshake.
//  6. Assert PRESETn = 0 during ACCESS -> PSEL = PENABLE = rsp_valid = 0 asynchronously;
//     after release, state = IDLE and cmd_ready = 1.

Source files
------------

// File: rtl/apb_sram_master.sv
// APB requester: takes one command at a time, runs the SETUP/ACCESS phases with an optional
// PREADY timeout, and hands back read data and error status on a valid/ready response port.
module apb_sram_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_tmo,
  output logic              busy,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  input  logic [DATA_W-1:0] PRDATA
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1) + 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e            r_state,     w_state_d;
  logic [ADDR_W-1:0] r_paddr,     w_paddr_d;
  logic              r_psel,      w_psel_d;
  logic              r_penable,   w_penable_d;
  logic              r_pwrite,    w_pwrite_d;
  logic [DATA_W-1:0] r_pwdata,    w_pwdata_d;
  logic              r_rsp_valid, w_rsp_valid_d;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_d;
  logic              r_rsp_err,   w_rsp_err_d;
  logic              r_rsp_tmo,   w_rsp_tmo_d;
  logic [CntW-1:0]   r_cnt,       w_cnt_d;
  logic [CntW-1:0]   w_cnt_inc;
  logic              w_tmo_hit;

  assign w_cnt_inc = r_cnt + CntW'(1);
  // A zero limit disables the timeout entirely.
  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == CntW'(TIMEOUT_CYCLES));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= StIdle;
      r_paddr     <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_tmo   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_d;
      r_paddr     <= w_paddr_d;
      r_psel      <= w_psel_d;
      r_penable   <= w_penable_d;
      r_pwrite    <= w_pwrite_d;
      r_pwdata    <= w_pwdata_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_rsp_rdata <= w_rsp_rdata_d;
      r_rsp_err   <= w_rsp_err_d;
      r_rsp_tmo   <= w_rsp_tmo_d;
      r_cnt       <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_paddr_d     = r_paddr;
    w_psel_d      = r_psel;
    w_penable_d   = r_penable;
    w_pwrite_d    = r_pwrite;
    w_pwdata_d    = r_pwdata;
    w_rsp_valid_d = r_rsp_valid;
    w_rsp_rdata_d = r_rsp_rdata;
    w_rsp_err_d   = r_rsp_err;
    w_rsp_tmo_d   = r_rsp_tmo;
    w_cnt_d       = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (cmd_valid) begin
          w_paddr_d  = cmd_addr;
          w_pwrite_d = cmd_write;
          w_pwdata_d = cmd_wdata;
          w_psel_d   = 1'b1;
          w_cnt_d    = '0;
          w_state_d  = StSetup;
        end
      end
      StSetup: begin
        w_penable_d = 1'b1;
        w_state_d   = StAccess;
      end
      StAccess: begin
        // PREADY takes priority over a timeout landing on the same edge.
        if (PREADY) begin
          w_rsp_rdata_d = r_pwrite ? '0 : PRDATA;
          w_rsp_err_d   = PSLVERR;
          w_rsp_tmo_d   = 1'b0;
          w_rsp_valid_d = 1'b1;
          w_psel_d      = 1'b0;
          w_penable_d   = 1'b0;
          w_state_d     = StResp;
        end else if (w_tmo_hit) begin
          w_rsp_rdata_d = '0;
          w_rsp_err_d   = 1'b1;
          w_rsp_tmo_d   = 1'b1;
          w_rsp_valid_d = 1'b1;
          w_psel_d      = 1'b0;
          w_penable_d   = 1'b0;
          w_state_d     = StResp;
        end else begin
          w_cnt_d = w_cnt_inc;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          w_rsp_valid_d = 1'b0;
          w_state_d     = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign cmd_ready = (r_state == StIdle);
  assign busy      = (r_state != StIdle);
  assign PADDR     = r_paddr;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PWDATA    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign rsp_tmo   = r_rsp_tmo;

endmodule

// File: tb/tb_apb_sram_master.sv
// Bench for apb_sram_master: a wait-state-programmable APB slave model, a response scoreboard
// and directed checks of phase timing, timeout, back-pressure and mid-transfer reset.
module tb_apb_sram_master;

  localparam int unsigned Tmo = 4;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_tmo;
  logic        busy;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] PRDATA;

  int          slv_wait = 0;
  logic        slv_err = 1'b0;
  logic [31:0] slv_rdata = '0;
  int          acc_cnt;

  int n_checks = 0;
  int n_fail = 0;
  logic [33:0] sb_q[$];

  apb_sram_master #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(Tmo)
  ) u_dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .rsp_tmo  (rsp_tmo),
    .busy     (busy),
    .PADDR    (PADDR),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .PRDATA   (PRDATA)
  );

  always #5 PCLK = ~PCLK;

  // Slave model: PREADY rises after slv_wait low ACCESS cycles.
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) acc_cnt <= 0;
    else if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else if (!(PSEL && PENABLE)) acc_cnt <= 0;
  end
  assign PREADY  = PSEL && PENABLE && (acc_cnt == slv_wait);
  assign PSLVERR = slv_err;
  assign PRDATA  = slv_rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Response scoreboard: the handshake completes on the next rising edge.
  always @(negedge PCLK) begin
    if (PRESETn && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) check("sb_unexpected_rsp", 64'd1, 64'd0);
      else check("sb_rsp", {30'd0, rsp_rdata, rsp_err, rsp_tmo}, {30'd0, sb_q.pop_front()});
    end
    if (PENABLE && !PSEL) check("penable_wo_psel", 64'd1, 64'd0);
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Drives one command and checks phase timing through to the first RESP cycle.
  task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic serr, input logic [31:0] srd,
                         input int exp_acc);
    int acc;
    logic tmo;
    slv_wait  = waits;
    slv_err   = serr;
    slv_rdata = srd;
    tmo = (waits >= Tmo);
    @(negedge PCLK);
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    if (tmo) sb_q.push_back({32'd0, 1'b1, 1'b1});
    else     sb_q.push_back({(wr ? 32'd0 : srd), serr, 1'b0});
    @(negedge PCLK);
    cmd_valid = 1'b0;
    check("setup_phase", 64'({PSEL, PENABLE}), 64'b10);
    check("setup_paddr", 64'(PADDR), 64'(addr));
    check("setup_pwrite", 64'(PWRITE), 64'(wr));
    if (wr) check("setup_pwdata", 64'(PWDATA), 64'(wdata));
    @(negedge PCLK);
    acc = 0;
    while (PSEL && PENABLE && acc < 40) begin
      check("access_paddr", 64'(PADDR), 64'(addr));
      acc++;
      @(negedge PCLK);
    end
    check("access_len", 64'(acc), 64'(exp_acc));
    check("resp_phase", 64'({PSEL, PENABLE, rsp_valid}), 64'b001);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    check(tag, 64'(busy), 64'd0);
  endtask

  initial begin
    #12;
    check("rst_psel_penable", 64'({PSEL, PENABLE, rsp_valid}), 64'd0);
    check("rst_paddr_pwdata", {PADDR, PWDATA}, 64'd0);
    check("rst_rsp", {30'd0, rsp_rdata, rsp_err, rsp_tmo}, 64'd0);
    check("rst_cmd_ready", 64'({cmd_ready, busy}), 64'b10);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // Zero-wait write: two PSEL cycles, response in the third cycle after acceptance.
    run_txn(1'b1, 32'h10, 32'hA5A5_0001, 0, 1'b0, 32'h1234_5678, 1);
    wait_idle("idle_after_write");

    // Three wait states: completes on the edge where the counter would reach the limit.
    run_txn(1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 4);
    wait_idle("idle_after_read");

    // Slave error on a read still returns PRDATA.
    run_txn(1'b0, 32'h44, 32'h0, 1, 1'b1, 32'hCAFE_0044, 2);
    wait_idle("idle_after_slverr");

    // PREADY never rises: abort after Tmo ACCESS cycles.
    run_txn(1'b0, 32'h80, 32'h0, 100, 1'b0, 32'hFFFF_FFFF, Tmo);
    wait_idle("idle_after_timeout");

    // Back-pressure: response held while a new command waits.
    rsp_ready = 1'b0;
    run_txn(1'b0, 32'h20, 32'h0, 0, 1'b0, 32'h0BAD_F00D, 1);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h24;
    cmd_wdata = 32'h5555_AAAA;
    slv_wait  = 0;
    slv_err   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      check("hold_rsp", {30'd0, rsp_rdata, rsp_err, rsp_tmo}, {30'd0, 32'h0BAD_F00D, 2'b00});
      check("hold_ctrl", 64'({rsp_valid, cmd_ready, PSEL}), 64'b100);
    end
    sb_q.push_back({32'd0, 1'b0, 1'b0});
    rsp_ready = 1'b1;
    @(negedge PCLK);
    check("post_hs_idle", 64'({cmd_ready, PSEL, rsp_valid}), 64'b100);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    check("queued_setup", 64'({PSEL, PENABLE, PADDR}), {32'd0, 2'b10, 32'h24});
    wait_idle("idle_after_queued");

    // Asynchronous reset during ACCESS drops the transfer.
    slv_wait = 100;
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h30;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    check("pre_reset_access", 64'({PSEL, PENABLE}), 64'b11);
    #2 PRESETn = 1'b0;
    #1;
    check("async_reset_outs", 64'({PSEL, PENABLE, rsp_valid, busy}), 64'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("after_reset_idle", 64'({cmd_ready, busy, PSEL}), 64'b100);
    repeat (3) @(negedge PCLK);
    check("no_rsp_after_reset", 64'(rsp_valid), 64'd0);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
